// File: rtl/conv_pkg.sv
// Shared types and width helpers for the windowed convolution processing element.
package conv_pkg;

  // Two-state controller: LOAD fills the kernel, RUN streams pixels.
  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Ceiling log2. clog2(1) = 0, clog2(9) = 4.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Full-precision accumulator width: product width plus growth for K*K terms.
  function automatic int acc_width(input int data_w, input int k);
    return 2 * data_w + clog2(k * k);
  endfunction

endpackage

// File: rtl/conv_line_buf.sv
// Tap shift register of (K-1)*IMG_W+K pixels; exposes the KxK window ending at
// the newest pixel. Window element (i,j) is packed at index i*K+j, row 0 being
// the oldest image row, column 0 the leftmost column.
module conv_line_buf #(
  parameter int DATA_W = 9,
  parameter int K      = 3,
  parameter int IMG_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      shift_en,
  input  logic [DATA_W-1:0]         din,
  output logic [K*K*DATA_W-1:0]     win
);

  localparam int LEN = (K - 1) * IMG_W + K;

  // taps[0] holds the newest pixel; taps[a*IMG_W+b] is a rows up, b columns left.
  logic [DATA_W-1:0] taps [LEN];

  // Shift one pixel in on every accepted pixel; hold during gaps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LEN; i++) taps[i] <= '0;
    end else if (shift_en) begin
      taps[0] <= din;
      for (int i = 1; i < LEN; i++) taps[i] <= taps[i-1];
    end
  end

  // Map shift-register taps onto the row-major window.
  always_comb begin
    win = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        win[(i*K+j)*DATA_W +: DATA_W] = taps[(K-1-i)*IMG_W + (K-1-j)];
      end
    end
  end

endmodule

// File: rtl/conv_pe_win.sv
// Sliding-window KxK convolution PE: loads a kernel, then streams a raster image
// and emits one full-precision result per complete window, two cycles after the
// window's last pixel is accepted.
// Handshake: a weight transfers on a rising edge where w_valid && w_ready, a pixel
// where px_valid && px_ready; out_valid is a one-cycle strobe with no backpressure.
module conv_pe_win
  import conv_pkg::*;
#(
  parameter int DATA_W = 9,
  parameter int K      = 3,
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  localparam int ACC_W = acc_width(DATA_W, K)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     w_valid,
  input  logic signed [DATA_W-1:0] w_data,
  output logic                     w_ready,
  input  logic                     px_valid,
  input  logic signed [DATA_W-1:0] px_data,
  output logic                     px_ready,
  input  logic                     reload,
  input  logic                     relu_en,
  output logic                     out_valid,
  output logic signed [ACC_W-1:0]  out_data,
  output logic                     frame_done
);

  localparam int NTAP   = K * K;
  localparam int IDX_W  = clog2(NTAP);
  localparam int COL_W  = clog2(IMG_W);
  localparam int ROW_W  = clog2(IMG_H);
  localparam int PROD_W = 2 * DATA_W;

  localparam logic [IDX_W-1:0] W_LAST   = IDX_W'(NTAP - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_WIN  = COL_W'(K - 1);
  localparam logic [ROW_W-1:0] ROW_WIN  = ROW_W'(K - 1);

  state_t                    state;
  logic [IDX_W-1:0]          w_idx;
  logic [COL_W-1:0]          col;
  logic [ROW_W-1:0]          row;
  logic                      reload_q;
  logic signed [DATA_W-1:0]  w_mem [NTAP];

  logic                      px_acc;
  logic                      win_done;
  logic                      frame_end;
  logic [NTAP*DATA_W-1:0]    win_flat;
  logic signed [DATA_W-1:0]  win_px [NTAP];

  logic                      s0_valid, s0_relu, s0_last;
  logic                      s1_valid, s1_relu, s1_last;
  logic signed [PROD_W-1:0]  prod [NTAP];
  logic signed [ACC_W-1:0]   sum;

  assign w_ready   = (state == LOAD);
  assign px_ready  = (state == RUN);
  assign px_acc    = (state == RUN) && px_valid;
  // Row gating keeps pixels left over from the previous frame out of any window.
  assign win_done  = px_acc && (col >= COL_WIN) && (row >= ROW_WIN);
  assign frame_end = px_acc && (col == COL_LAST) && (row == ROW_LAST);

  // Controller: kernel load sequencing, raster counters and deferred reload.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= LOAD;
      w_idx    <= '0;
      col      <= '0;
      row      <= '0;
      reload_q <= 1'b0;
      for (int i = 0; i < NTAP; i++) w_mem[i] <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (w_valid) begin
            w_mem[w_idx] <= w_data;
            if (w_idx == W_LAST) begin
              w_idx <= '0;
              state <= RUN;
            end else begin
              w_idx <= w_idx + 1'b1;
            end
          end
        end
        RUN: begin
          if (reload) reload_q <= 1'b1;
          if (px_valid) begin
            if (col == COL_LAST) begin
              col <= '0;
              if (row == ROW_LAST) begin
                row <= '0;
                // A reload arriving with the last pixel still counts for this frame.
                if (reload_q || reload) begin
                  state    <= LOAD;
                  reload_q <= 1'b0;
                end
              end else begin
                row <= row + 1'b1;
              end
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  conv_line_buf #(
    .DATA_W (DATA_W),
    .K      (K),
    .IMG_W  (IMG_W)
  ) u_line_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (px_acc),
    .din      (px_data),
    .win      (win_flat)
  );

  // Unpack the window into signed pixels for the multiplier array.
  always_comb begin
    for (int i = 0; i < NTAP; i++) win_px[i] = win_flat[i*DATA_W +: DATA_W];
  end

  // Stage 0: mark the edge at which a window completed, with its relu/last flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s0_valid <= 1'b0;
      s0_relu  <= 1'b0;
      s0_last  <= 1'b0;
    end else begin
      s0_valid <= win_done;
      s0_relu  <= relu_en;
      s0_last  <= frame_end;
    end
  end

  // Stage 1: register the K*K products; the buffer still holds the completed window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_relu  <= 1'b0;
      s1_last  <= 1'b0;
      for (int i = 0; i < NTAP; i++) prod[i] <= '0;
    end else begin
      s1_valid <= s0_valid;
      s1_relu  <= s0_relu;
      s1_last  <= s0_last;
      if (s0_valid) begin
        for (int i = 0; i < NTAP; i++) prod[i] <= PROD_W'(w_mem[i]) * PROD_W'(win_px[i]);
      end
    end
  end

  // Adder tree over the registered products, at full accumulator width.
  always_comb begin
    sum = '0;
    for (int i = 0; i < NTAP; i++) sum = sum + ACC_W'(prod[i]);
  end

  // Stage 2: register the result (optionally clamped) and the frame-end pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= s1_valid;
      frame_done <= s1_valid && s1_last;
      if (s1_valid) out_data <= (s1_relu && sum[ACC_W-1]) ? '0 : sum;
    end
  end

endmodule

// File: tb/tb_conv_pe_win.sv
// Bench for conv_pe_win with K=3 on a 4x4 image. Drivers push the expected
// result, frame_done flag and arrival cycle of every complete window into queues;
// a negedge monitor pops and compares whenever out_valid is seen.
module tb_conv_pe_win;

  localparam int DATA_W = 9;
  localparam int K      = 3;
  localparam int IMG_W  = 4;
  localparam int IMG_H  = 4;
  localparam int ACC_W  = 22;  // 2*9 + ceil(log2(9))

  logic                     clk;
  logic                     rst_n;
  logic                     w_valid;
  logic signed [DATA_W-1:0] w_data;
  logic                     w_ready;
  logic                     px_valid;
  logic signed [DATA_W-1:0] px_data;
  logic                     px_ready;
  logic                     reload;
  logic                     relu_en;
  logic                     out_valid;
  logic signed [ACC_W-1:0]  out_data;
  logic                     frame_done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [ACC_W-1:0] exp_q[$];
  bit               exp_last_q[$];
  int               exp_cyc_q[$];

  conv_pe_win #(
    .DATA_W (DATA_W),
    .K      (K),
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .w_valid    (w_valid),
    .w_data     (w_data),
    .w_ready    (w_ready),
    .px_valid   (px_valid),
    .px_data    (px_data),
    .px_ready   (px_ready),
    .reload     (reload),
    .relu_en    (relu_en),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .frame_done (frame_done)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Monitor / scoreboard.
  always @(negedge clk) begin
    logic [ACC_W-1:0] e;
    bit               l;
    int               c;
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        l = exp_last_q.pop_front();
        c = exp_cyc_q.pop_front();
        check("out_data", longint'(out_data), longint'($signed(e)));
        check("frame_done", longint'(frame_done), longint'(l));
        check("out_latency_cycle", cyc, c);
      end
    end else if (frame_done) begin
      check("frame_done_without_valid", 1, 0);
    end
  end

  task automatic check_reset_outputs();
    check("rst_w_ready", w_ready, 1);
    check("rst_px_ready", px_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", longint'(out_data), 0);
    check("rst_frame_done", frame_done, 0);
  endtask

  // mode 0: w[i][j] = i+j+1, mode 1: all 1, mode 2: all -1.
  // Pixels driven meanwhile must be ignored in LOAD.
  task automatic load_weights(input int mode);
    int wv;
    check("load_w_ready", w_ready, 1);
    check("load_px_ready", px_ready, 0);
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        wv = (mode == 0) ? (i + j + 1) : ((mode == 1) ? 1 : -1);
        w_valid  = 1'b1;
        w_data   = DATA_W'(wv);
        px_valid = 1'b1;
        px_data  = 9'sd7;
        @(negedge clk);
      end
    end
    w_valid  = 1'b0;
    px_valid = 1'b0;
    check("after_load_px_ready", px_ready, 1);
    check("after_load_w_ready", w_ready, 0);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_queue_empty", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // pmode 0: all pixels 2, pmode 1: pixels 1..16 raster. gap inserts an idle
  // cycle after each pixel. reload_at pulses reload with that pixel (-1 = none).
  // Junk weights are driven throughout and must be ignored in RUN.
  task automatic send_frame(input int pmode, input int gap, input int relu, input int reload_at,
                            input int e0, input int e1, input int e2, input int e3);
    int ev [4];
    int n;
    ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
    n = 0;
    relu_en = relu[0];
    for (int idx = 0; idx < IMG_W * IMG_H; idx++) begin
      px_valid = 1'b1;
      px_data  = (pmode == 0) ? 9'sd2 : DATA_W'(idx + 1);
      w_valid  = 1'b1;
      w_data   = 9'sd85;
      reload   = (idx == reload_at);
      if ((idx / IMG_W) >= K - 1 && (idx % IMG_W) >= K - 1) begin
        exp_q.push_back(ACC_W'(ev[n]));
        exp_last_q.push_back(idx == IMG_W * IMG_H - 1);
        exp_cyc_q.push_back(cyc + 3);
        n++;
      end
      @(negedge clk);
      reload = 1'b0;
      if (gap != 0) begin
        px_valid = 1'b0;
        @(negedge clk);
      end
    end
    px_valid = 1'b0;
    w_valid  = 1'b0;
    if (reload_at >= 0) begin
      check("reload_w_ready", w_ready, 1);
      check("reload_px_ready", px_ready, 0);
    end else begin
      check("stay_run_px_ready", px_ready, 1);
    end
    wait_drain();
  endtask

  // Feed n pixels of a frame, then reset; nothing may come out afterwards.
  task automatic reset_mid(input int n);
    for (int idx = 0; idx < n; idx++) begin
      px_valid = 1'b1;
      px_data  = 9'sd2;
      @(negedge clk);
    end
    px_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("no_stale_out", exp_q.size(), 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    w_valid  = 1'b0;
    w_data   = '0;
    px_valid = 1'b0;
    px_data  = '0;
    reload   = 1'b0;
    relu_en  = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs();

    // Ramp kernel 1 2 3/2 3 4/3 4 5.
    load_weights(0);
    send_frame(0, 0, 0, -1, 54, 54, 54, 54);
    send_frame(1, 0, 0, -1, 192, 219, 300, 327);
    send_frame(0, 1, 0, -1, 54, 54, 54, 54);
    // Reload requested mid-frame: frame completes with the old kernel.
    send_frame(0, 0, 0, 5, 54, 54, 54, 54);
    load_weights(1);
    // Reload together with the last pixel.
    send_frame(0, 0, 0, 15, 18, 18, 18, 18);
    load_weights(2);
    send_frame(0, 0, 0, -1, -18, -18, -18, -18);
    send_frame(0, 0, 1, -1, 0, 0, 0, 0);

    // Reset mid-frame, then a full reload and frame.
    reset_mid(7);
    load_weights(0);
    send_frame(0, 0, 0, -1, 54, 54, 54, 54);
    // Reset with a window in flight in the pipeline.
    reset_mid(11);
    load_weights(0);
    send_frame(0, 0, 0, -1, 54, 54, 54, 54);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
